// File: rtl/l2d_req_arbiter.sv
// l2d_req_arbiter: merges two L2 data-slice request channels into the
// directory request channel. Each slice has a 2-entry skid FIFO, arbitration
// is round-robin, and the output stage is registered and tagged with the
// source slice.
// Ports: clk, reset (sync, active-high);
//   l2d_0todr_req_valid/_retry/payload : slice 0 request channel
//   l2d_1todr_req_valid/_retry/payload : slice 1 request channel
//   l2todr_req_valid/_retry/payload    : merged directory channel
//   l2todr_req_src                     : source slice of l2todr_req
module l2d_req_arbiter #(
   parameter int REQ_W      = 96,
   parameter int FIFO_DEPTH = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             l2d_0todr_req_valid,
   output logic             l2d_0todr_req_retry,
   input  logic [REQ_W-1:0] l2d_0todr_req,
   input  logic             l2d_1todr_req_valid,
   output logic             l2d_1todr_req_retry,
   input  logic [REQ_W-1:0] l2d_1todr_req,
   output logic             l2todr_req_valid,
   input  logic             l2todr_req_retry,
   output logic [REQ_W-1:0] l2todr_req,
   output logic             l2todr_req_src
);

   localparam logic [1:0] FULL = 2'(FIFO_DEPTH);

   logic [1:0]       in_v;
   logic [REQ_W-1:0] in_d [2];

   logic [REQ_W-1:0] mem  [2][2];
   logic [1:0]       cnt  [2];
   logic             wp   [2];
   logic             rp   [2];

   logic [1:0]       full;
   logic [1:0]       ne;
   logic [1:0]       enq;
   logic [1:0]       deq;
   logic [REQ_W-1:0] head [2];

   logic             out_v;
   logic [REQ_W-1:0] out_data;
   logic             out_src;
   logic             last_gnt;

   logic             load;
   logic             grant;
   logic             win;

   assign in_v[0] = l2d_0todr_req_valid;
   assign in_v[1] = l2d_1todr_req_valid;
   assign in_d[0] = l2d_0todr_req;
   assign in_d[1] = l2d_1todr_req;

   always_comb begin
      for (int i = 0; i < 2; i++) begin
         full[i] = (cnt[i] == FULL);
         ne[i]   = (cnt[i] != 2'd0);
         enq[i]  = in_v[i] && !full[i];
         head[i] = mem[i][rp[i]];
      end
   end

   // Retry comes straight from the occupancy flops.
   assign l2d_0todr_req_retry = full[0];
   assign l2d_1todr_req_retry = full[1];

   // Output stage may drain and refill in the same cycle.
   assign load  = !out_v || !l2todr_req_retry;
   assign grant = load && (ne != 2'b00);

   // On a tie, the slice that did not win last time goes next.
   always_comb begin
      win = 1'b0;
      unique case (1'b1)
         ne[0] && ne[1]:  win = ~last_gnt;
         ne[1] && !ne[0]: win = 1'b1;
         default:         win = 1'b0;
      endcase
   end

   assign deq[0] = grant && !win;
   assign deq[1] = grant && win;

   always_ff @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (reset) begin
            cnt[i] <= 2'd0;
            wp[i]  <= 1'b0;
            rp[i]  <= 1'b0;
         end else begin
            if (enq[i])
               mem[i][wp[i]] <= in_d[i];
            wp[i]  <= wp[i] ^ enq[i];
            rp[i]  <= rp[i] ^ deq[i];
            cnt[i] <= cnt[i] + 2'(enq[i]) - 2'(deq[i]);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_v    <= 1'b0;
         out_data <= '0;
         out_src  <= 1'b0;
         last_gnt <= 1'b1;
      end else if (load) begin
         if (grant) begin
            out_v    <= 1'b1;
            out_data <= head[win];
            out_src  <= win;
            last_gnt <= win;
         end else begin
            out_v    <= 1'b0;
         end
      end
   end

   assign l2todr_req_valid = out_v;
   assign l2todr_req       = out_data;
   assign l2todr_req_src   = out_src;

endmodule

// File: doc/l2d_req_arbiter.md
Name: l2d_req_arbiter

Overview:
- Merges the request channels of two L2 data slices (l2d_0, l2d_1) into the single directory request channel (l2todr_req).
- Each input has a 2-entry skid FIFO. A registered output stage drives the directory side.
- Arbitration between non-empty FIFOs is round-robin.
- Every issued request is tagged with its source slice, so the directory aggregator can route responses back.

Parameters:
- REQ_W, 96: width of one request payload (packed I_l2todr_req_type).
- FIFO_DEPTH, 2: entries per input skid FIFO. Fixed at 2; other values are not supported.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- l2d_0todr_req_valid  in  1  slice 0 request valid
- l2d_0todr_req_retry  out  1  slice 0 back-pressure
- l2d_0todr_req  in  REQ_W  slice 0 request payload
- l2d_1todr_req_valid  in  1  slice 1 request valid
- l2d_1todr_req_retry  out  1  slice 1 back-pressure
- l2d_1todr_req  in  REQ_W  slice 1 request payload
- l2todr_req_valid  out  1  merged request valid
- l2todr_req_retry  in  1  directory back-pressure
- l2todr_req  out  REQ_W  merged request payload
- l2todr_req_src  out  1  source slice of the current l2todr_req (0 or 1)

Behaviour:
- Clocking and reset: one clock, clk. reset is synchronous and active-high.
- Handshake:
  - A transfer occurs on a channel in any cycle where valid=1 and retry=0.
  - A sender holds valid and payload stable while retry=1.
  - valid must not depend combinationally on retry.
- Input FIFOs:
  - Each FIFO has a 2-bit occupancy count cnt_i (0..2) and write/read pointers that wrap 1->0.
  - *_req_retry = (cnt_i == 2). It is derived from flops only, with no combinational path from any input.
  - An enqueue and a dequeue in the same cycle leave cnt unchanged. With cnt=2 that case cannot occur, because retry blocks the enqueue.
  - Entries are delivered in strict FIFO order per source.
- Output stage:
  - Holds the flops out_v, out_data and out_src.
  - load = !out_v || !l2todr_req_retry. That is, it can drain and refill in the same cycle, giving 1 request/cycle throughput.
  - On load with at least one FIFO non-empty: the winning FIFO head is written to out_data, the winner id to out_src, and out_v is set to 1. The winner is dequeued.
  - On load with both FIFOs empty: out_v is cleared to 0 and out_data/out_src hold.
  - While out_v=1 and retry=1, out_data and out_src are held bit-stable.
- Arbitration:
  - A 1-bit pointer last_gnt records the most recent winner.
  - If only one FIFO is non-empty, it wins.
  - If both are non-empty, the FIFO != last_gnt wins.
  - last_gnt updates only on an actual grant (load && any non-empty).
  - No requester waits more than one grant behind the other.
- Latency: a request accepted at cycle t into an empty FIFO, with the output stage free, appears on l2todr_req_valid at t+2. There is no bypass path.
- Reset values (effective the cycle after reset is sampled high):
  - cnt_0 = cnt_1 = 0, so both retry outputs = 0.
  - out_v = 0, l2todr_req = 0, l2todr_req_src = 0.
  - last_gnt = 1, so slice 0 wins the first tie.
- Reset mid-operation: all buffered and staged requests are discarded. No stale valid appears after reset is released. Upstream re-issue is the L2's responsibility.
- Simultaneous events: an input enqueue and a grant of the same FIFO in one cycle is legal. The head is dequeued while the new entry is written at the tail.

Test Plan:
- Reset with both FIFOs full and out_v=1 -> next cycle all valid/retry outputs 0 and l2todr_req=0; no output valid until new input arrives.
- Single request: slice 0 sends 0xA5 at cycle t, directory retry=0 -> l2todr_req_valid=1 only at t+2, l2todr_req=0xA5, src=0, then valid returns to 0.
- Tie: both slices send at cycle t (0x10 from slice 0, 0x20 from slice 1) -> 0x10/src0 at t+2, 0x20/src1 at t+3. A subsequent tie issues slice 0 first again (last_gnt=1).
- Back-pressure:
  - Stimulus: directory retry=1 for 6 cycles while slice 0 streams 0x1, 0x2, 0x3, 0x4.
  - Required while retry=1: output holds 0x1 stable; the FIFO holds 0x2 and 0x3; l2d_0todr_req_retry=1 while 0x4 is stalled.
  - Required after retry drops: 0x1, 0x2, 0x3, 0x4 issue in order on consecutive cycles, with no loss or duplication.
- Saturation: both slices stream 8 requests each with no back-pressure -> 16 outputs, src strictly alternating 0,1,0,1..., per-source order preserved.
- Same-cycle drain and refill: out_v=1 and retry drops while slice 1's FIFO is non-empty -> a new payload appears the very next cycle with no valid gap.
